ov_sccb_master: RTL
===================

# ov_sccb_master

Parametrised SCCB master for Omnivision camera configuration, per SCCB spec v2.2. It runs 3-phase write, 2-phase write and read transactions (a 2-phase write followed by a 2-phase read) on behalf of the camera init sequencer. It generates SIO_C from `clk` through a programmable divider. It supports 8-bit or 16-bit register sub-addresses, and uses a start/busy/done handshake.

## Interface
Parameters:
- `CLK_DIV`, default 125: `clk` cycles per SIO_C quarter-period. Must be ≥1.
- `SUB_BYTES`, default 1: sub-address length in bytes, 1 or 2. Sent MSB byte first.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  request. Sampled only while `busy`=0.
- `mode`  in  2  0 = 3-phase write, 1 = 2-phase write, 2 = read, 3 = reserved (treated as 1)
- `dev_id`  in  7  7-bit slave ID. The R/W bit is appended by the block.
- `sub_addr`  in  8·SUB_BYTES  register address
- `w_data`  in  8  write data
- `r_data`  out  8  read data. Valid from `done` until the next accepted read.
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse at completion
- `sio_c`  out  1  SCCB clock
- `sio_d_o`  out  1  SIO_D output value
- `sio_d_oe`  out  1  SIO_D output enable. The top level builds the tri-state.
- `sio_d_i`  in  1  SIO_D input

## Operation
- Reset values: `busy`=0, `done`=0, `r_data`=0x00, `sio_c`=1, `sio_d_o`=1, `sio_d_oe`=1.
  - Reset asserted mid-transaction returns all outputs to these values immediately. No stop condition is generated.
- Accept: on the first `clk` edge with `start`=1 and `busy`=0:
  - Latch `mode`, `dev_id`, `sub_addr` and `w_data`.
  - `busy`=1 from the next cycle.
  - `start` is ignored while `busy`=1.
- Tick: a divider counter runs 0..CLK_DIV-1 while busy. Each wrap advances one quarter.
- State machine: IDLE → START → BYTE → STOP → (GAP → START → BYTE → STOP, read only) → DONE → IDLE.
  - BYTE iterates phases, with a 9-bit counter 0..8 per phase.
  - DONE lasts one `clk` cycle: it asserts `done` and drops `busy`.
- Phase sequence per mode:
  - mode 0: ID|0, sub-address byte(s), w_data.
  - mode 1: ID|0, sub-address byte(s).
  - mode 2: transaction A = ID|0, sub-address byte(s), STOP. Then GAP, then transaction B = ID|1, read byte, STOP.
- Ninth bit of each phase:
  - Write phases and ID phases: the "don't care" bit. `sio_d_oe`=0 and `sio_d_i` is ignored.
  - Read byte: NA bit. The master drives 1 with `sio_d_oe`=1.
- Read data bits: `sio_d_oe`=0. Each bit is sampled into a shift register MSB first. `r_data` updates at DONE only.
- `sio_d_oe`=1 at all other times.

## Timing
Quarter waveforms, listed as (sio_c, sio_d) per quarter:
- START: q0 (1,1), q1 (1,0), q2 (1,0), q3 (0,0).
- Each bit:
  - q0 and q1: `sio_c`=0. `sio_d_o` updates at the q0 boundary.
  - q2 and q3: `sio_c`=1.
  - `sio_d_i` is sampled on the last `clk` of q2.
- STOP: q0 (0,0), q1 (1,0), q2 (1,1), q3 (1,1).
- GAP: 4 quarters at (1,1).

Quarter counts:
- Transaction with P phases: 8 + 36·P quarters.
- Total duration: mode 0 = 8+36·(2+SUB_BYTES). mode 1 = 8+36·(1+SUB_BYTES). mode 2 = that mode-1 count + 4 + 80.

Latency:
- `done` pulses exactly (total quarters)·CLK_DIV + 1 `clk` cycles after the accepting edge.
- A new `start` may be accepted in the cycle after `done`.
- `start` asserted in the same cycle as `done` is ignored.

## Test plan
- CLK_DIV=2, SUB_BYTES=1, mode 0, dev_id 0x21, sub 0x12, w_data 0x80 → SIO_D bit stream 0x42 X, 0x12 X, 0x80 X, with START/STOP edges occurring only while `sio_c`=1; `done` at cycle 233; `busy` high cycles 1..232.
- Same setup, mode 2, sub 0x0A, slave model returns 0xA5 → transaction A (0x42, 0x0A), 4-quarter GAP, transaction B (0x43), NA driven 1, `r_data`=0xA5; `done` after 164·2+1 cycles.
- SUB_BYTES=2, mode 1, sub 0x3008 → bytes 0x42, 0x30, 0x08 in order; 116 quarters.
- `start` pulsed mid-transaction and again in the `done` cycle → both ignored; no second transaction starts.
- Reset deasserted-then-asserted during the sub-address phase → immediate `sio_c`=1, `sio_d_o`=1, `sio_d_oe`=1, `busy`=0; the next `start` runs a full correct transaction.
- CLK_DIV=1, mode 0 → identical bit stream; `done` at cycle 117.

Source files
------------

// File: rtl/ov_sccb_master.sv
// SCCB master for Omnivision camera register access: 3-phase write, 2-phase
// write and read (2-phase write + 2-phase read) with a programmable SIO_C divider.
module ov_sccb_master #(
  parameter int CLK_DIV   = 125,
  parameter int SUB_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [6:0]             dev_id,
  input  logic [8*SUB_BYTES-1:0] sub_addr,
  input  logic [7:0]             w_data,
  output logic [7:0]             r_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sio_c,
  output logic                   sio_d_o,
  output logic                   sio_d_oe,
  input  logic                   sio_d_i
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam int SW = 8 * SUB_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_STOP, S_GAP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [3:0]      bit_q, bit_d;
  logic [2:0]      ph_q, ph_d;
  logic            rd_b_q, rd_b_d;
  logic [1:0]      mode_q, mode_d;
  logic [6:0]      id_q, id_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [7:0]      wd_q, wd_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            tick;
  logic            rd_phase;
  logic [2:0]      last_idx;
  logic [7:0]      tx_byte;

  assign tick     = (div_q == DIV_MAX);
  assign rd_phase = rd_b_q && (ph_q == 3'd1);

  // Phase 0 is always the ID byte; then sub-address bytes MSB first; then write data.
  always_comb begin
    tx_byte = wd_q;
    if (ph_q == 3'd0) begin
      tx_byte = {id_q, rd_b_q};
    end else begin
      for (int i = 0; i < SUB_BYTES; i++) begin
        if (ph_q == 3'(i + 1)) tx_byte = sub_q[SW-8-8*i +: 8];
      end
    end
  end

  always_comb begin
    last_idx = 3'(SUB_BYTES);
    if (rd_b_q)             last_idx = 3'd1;
    else if (mode_q == 2'd0) last_idx = 3'(SUB_BYTES + 1);
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    rd_b_d  = rd_b_q;
    mode_d  = mode_q;
    id_d    = id_q;
    sub_d   = sub_q;
    wd_d    = wd_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 4'd0;
          ph_d    = 3'd0;
          rd_b_d  = 1'b0;
          mode_d  = (mode == 2'd3) ? 2'd1 : mode;
          id_d    = dev_id;
          sub_d   = sub_addr;
          wd_d    = w_data;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (state_q == S_BYTE && rd_phase && bit_q < 4'd8 && qtr_q == 2'd2)
            sh_d = {sh_q[6:0], sio_d_i};
          if (qtr_q == 2'd3) begin
            case (state_q)
              S_START: begin
                state_d = S_BYTE;
                bit_d   = 4'd0;
                ph_d    = 3'd0;
              end
              S_BYTE: begin
                if (bit_q == 4'd8) begin
                  bit_d = 4'd0;
                  if (ph_q == last_idx) state_d = S_STOP;
                  else                  ph_d    = ph_q + 3'd1;
                end else begin
                  bit_d = bit_q + 4'd1;
                end
              end
              S_STOP: begin
                if (mode_q == 2'd2 && !rd_b_q) begin
                  state_d = S_GAP;
                end else begin
                  state_d = S_DONE;
                  if (mode_q == 2'd2) rdata_d = sh_q;
                end
              end
              S_GAP: begin
                state_d = S_START;
                rd_b_d  = 1'b1;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 4'd0;
      ph_q    <= 3'd0;
      rd_b_q  <= 1'b0;
      mode_q  <= 2'd0;
      id_q    <= 7'd0;
      sub_q   <= '0;
      wd_q    <= 8'd0;
      sh_q    <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      rd_b_q  <= rd_b_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      wd_q    <= wd_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign r_data = rdata_q;

  // Bus waveform is decoded straight from the registered state so reset takes effect at once.
  always_comb begin
    sio_c    = 1'b1;
    sio_d_o  = 1'b1;
    sio_d_oe = 1'b1;
    case (state_q)
      S_START: begin
        sio_c   = (qtr_q != 2'd3);
        sio_d_o = (qtr_q == 2'd0);
      end
      S_BYTE: begin
        sio_c = qtr_q[1];
        if (bit_q == 4'd8) begin
          sio_d_oe = rd_phase;
        end else if (rd_phase) begin
          sio_d_oe = 1'b0;
        end else begin
          sio_d_o = tx_byte[3'(4'd7 - bit_q)];
        end
      end
      S_STOP: begin
        sio_c   = (qtr_q != 2'd0);
        sio_d_o = qtr_q[1];
      end
      default: ;
    endcase
  end

endmodule
